// File: rtl/reg_fetch_pkg.sv
// reg_fetch_pkg: shared types and constants for the register operand fetch slice
// Contents: fetch FSM state enum, PC register address, default PC offset, lane indices.
package reg_fetch_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} fetch_state_e;
    localparam logic [3:0] PC_ADDR = 4'hF;
    localparam int PC_OFFSET_DEF = 8;
    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;
    localparam int N_LANES = 3;
endpackage

// File: rtl/reg_operand_fetch_operand_select.sv
// operand_select: one operand lane's source priority mux, bypass register and operand register
// Ports: clk/rst_n (async active-low), issue_i/capture_i (fetch phase), use_i (lane enabled),
//        addr_i (latched lane address), rf_data_i (register file read data), pc_i,
//        wb_enable_i/wb_address_i/wb_data_i (writeback), op_o (registered operand).
// Optional feature: REG_FETCH_FWD_EN builds writeback forwarding and the bypass register.
module operand_select
    import reg_fetch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int PC_OFFSET = PC_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic              capture_i,
    input  logic              use_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              wb_enable_i,
    input  logic [ADDR_W-1:0] wb_address_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] op_o
);
    logic [DATA_W-1:0] op_q, op_d, fwd_data;
    logic              fwd_hit;
`ifdef REG_FETCH_FWD_EN
    logic              byp_hit_q, byp_hit_d, wb_hit;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    always_comb begin
        wb_hit     = wb_enable_i && wb_address_i == addr_i;
        byp_hit_d  = issue_i ? wb_hit : byp_hit_q;
        byp_data_d = issue_i && wb_hit ? wb_data_i : byp_data_q;
        // a writeback seen during CAPTURE is newer than one held from ISSUE
        fwd_hit    = wb_hit || byp_hit_q;
        fwd_data   = wb_hit ? wb_data_i : byp_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_enable_i, wb_address_i, wb_data_i, issue_i};
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
`endif
    always_comb begin
        op_d = !capture_i                    ? op_q
             : !use_i                        ? '0
             : addr_i == ADDR_W'(PC_ADDR)    ? pc_i + DATA_W'(PC_OFFSET)
             : fwd_hit                       ? fwd_data
             :                                 rf_data_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_q <= '0;
        else        op_q <= op_d;
    end
    assign op_o = op_q;
endmodule

// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch: read-side sequencer turning a 3-source decode request into register file reads and operands
// Ports: clk, rst_n (async active-low); req_* decode request (valid/ready, three addresses, per-lane use);
//        rf_in_address_*/rf_read_enable_* registered read port drive, rf_out_data_* read data (next cycle);
//        pc; wb_* writeback mirror; op_valid/op_ready and op_a/op_b/op_c towards execute.
// Optional feature: REG_FETCH_FWD_EN enables writeback forwarding into the operands.
module reg_operand_fetch
    import reg_fetch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int PC_OFFSET = PC_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [ADDR_W-1:0] req_addr_c,
    input  logic [2:0]        req_use,
    output logic [ADDR_W-1:0] rf_in_address_1,
    output logic [ADDR_W-1:0] rf_in_address_2,
    output logic [ADDR_W-1:0] rf_in_address_3,
    output logic              rf_read_enable_1,
    output logic              rf_read_enable_2,
    output logic              rf_read_enable_3,
    input  logic [DATA_W-1:0] rf_out_data_1,
    input  logic [DATA_W-1:0] rf_out_data_2,
    input  logic [DATA_W-1:0] rf_out_data_3,
    input  logic [DATA_W-1:0] pc,
    input  logic              wb_enable,
    input  logic [ADDR_W-1:0] wb_address,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_c
);
    fetch_state_e                   state_q, state_d;
    logic                           rdy_q, accept;
    logic [N_LANES-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [N_LANES-1:0]             use_q, use_d, en_q, en_d;
    logic [N_LANES-1:0][DATA_W-1:0] rf_data, op;
    always_comb begin
        // rdy_q keeps req_ready low until the first clock after reset release
        req_ready = rdy_q && (state_q == IDLE || (state_q == HOLD && op_ready));
        accept    = req_valid && req_ready;
        state_d   = accept                           ? ISSUE
                  : state_q == ISSUE                 ? CAPTURE
                  : state_q == CAPTURE               ? HOLD
                  : state_q == HOLD && op_ready      ? IDLE
                  :                                    state_q;
        addr_d    = accept ? {req_addr_c, req_addr_b, req_addr_a} : addr_q;
        use_d     = accept ? req_use : use_q;
        en_d      = accept ? req_use : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            use_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            addr_q  <= addr_d;
            use_q   <= use_d;
            en_q    <= en_d;
        end
    end
    assign rf_data = {rf_out_data_3, rf_out_data_2, rf_out_data_1};
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        operand_select #(
            .DATA_W    (DATA_W),
            .ADDR_W    (ADDR_W),
            .PC_OFFSET (PC_OFFSET)
        ) u_sel (
            .clk          (clk),
            .rst_n        (rst_n),
            .issue_i      (state_q == ISSUE),
            .capture_i    (state_q == CAPTURE),
            .use_i        (use_q[l]),
            .addr_i       (addr_q[l]),
            .rf_data_i    (rf_data[l]),
            .pc_i         (pc),
            .wb_enable_i  (wb_enable),
            .wb_address_i (wb_address),
            .wb_data_i    (wb_data),
            .op_o         (op[l])
        );
    end
    assign rf_in_address_1  = addr_q[LANE_A];
    assign rf_in_address_2  = addr_q[LANE_B];
    assign rf_in_address_3  = addr_q[LANE_C];
    assign rf_read_enable_1 = en_q[LANE_A];
    assign rf_read_enable_2 = en_q[LANE_B];
    assign rf_read_enable_3 = en_q[LANE_C];
    assign op_valid         = state_q == HOLD;
    assign op_a             = op[LANE_A];
    assign op_b             = op[LANE_B];
    assign op_c             = op[LANE_C];
endmodule
